// File: rtl/mii_pkg.sv
// Shared types and constants for the MII receive deframer: FSM states,
// preamble/SFD nibbles and the CRC-32 parameters.
package mii_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_e;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;

  localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational one-byte step of the reflected Ethernet CRC-32 (LSB first).
module eth_crc32_d8
  import mii_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_v;

  // NOTE: crc_v is fully assigned before any conditional use, so no latch is inferred.
  always_comb begin
    crc_v = crc_i ^ {24'h000000, data_i};
    for (int i = 0; i < 8; i++) begin
      crc_v = crc_v[0] ? ((crc_v >> 1) ^ CRC_POLY) : (crc_v >> 1);
    end
    crc_o = crc_v;
  end

endmodule

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, assembles nibbles into bytes,
// optionally removes the FCS and flags bad frames on the last output byte.
module mii_rx_deframer
  import mii_pkg::*;
#(
  parameter int STRIP_FCS = 1
) (
  input  logic       mac_mii_rxc,
  input  logic       mac_mii_rxrst,
  input  logic       mac_mii_rxdv,
  input  logic       mac_mii_rxer,
  input  logic [3:0] mac_mii_rxd,
  output logic       o_tvalid,
  output logic [7:0] o_tdata,
  output logic       o_tlast,
  output logic       o_tuser,
  output logic       o_drop
);

  rx_state_e       state_q;
  logic            phase_q;
  logic            err_q;
  logic [31:0]     crc_q;
  logic [31:0]     crc_d;
  logic [3:0]      nib_lo_q;
  logic [3:0][7:0] dl_q;
  logic [3:0]      dl_vld_q;
  logic [7:0]      pend_q;
  logic            pend_vld_q;
  logic            fin_q;
  logic            fin_user_q;

  logic [7:0]      byte_d;
  logic [7:0]      pend_d;
  logic            byte_done;
  logic            pend_shift;

  assign byte_d     = {mac_mii_rxd, nib_lo_q};
  assign byte_done  = (state_q == ST_DATA) && mac_mii_rxdv && phase_q;
  // With FCS stripping a byte reaches pending only after four newer bytes exist.
  assign pend_shift = (STRIP_FCS == 0) || dl_vld_q[3];
  assign pend_d     = (STRIP_FCS != 0) ? dl_q[3] : byte_d;

  eth_crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (byte_d),
    .crc_o  (crc_d)
  );

  // NOTE: byte storage has no reset; the valid flags below guard every use of it.
  always_ff @(posedge mac_mii_rxc) begin
    if ((state_q == ST_DATA) && mac_mii_rxdv && !phase_q) nib_lo_q <= mac_mii_rxd;
    if (byte_done) dl_q <= {dl_q[2:0], byte_d};
    if (byte_done && pend_shift) pend_q <= pend_d;
  end

  // NOTE: non-blocking assignments so every branch sees the pre-edge register values.
  always_ff @(posedge mac_mii_rxc or posedge mac_mii_rxrst) begin
    if (mac_mii_rxrst) begin
      state_q    <= ST_DROP;
      phase_q    <= 1'b0;
      err_q      <= 1'b0;
      crc_q      <= CRC_INIT;
      dl_vld_q   <= '0;
      pend_vld_q <= 1'b0;
      fin_q      <= 1'b0;
      fin_user_q <= 1'b0;
      o_tvalid   <= 1'b0;
      o_tdata    <= 8'h00;
      o_tlast    <= 1'b0;
      o_tuser    <= 1'b0;
      o_drop     <= 1'b0;
    end else begin
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      o_tuser  <= 1'b0;
      o_drop   <= 1'b0;
      fin_q    <= 1'b0;

      // Last byte goes out one cycle late so o_tvalid never fires back to back.
      if (fin_q) begin
        o_tvalid   <= 1'b1;
        o_tdata    <= pend_q;
        o_tlast    <= 1'b1;
        o_tuser    <= fin_user_q;
        pend_vld_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (mac_mii_rxdv) begin
            if (mac_mii_rxd == PREAMBLE_NIB) begin
              state_q <= ST_PREAMBLE;
            end else begin
              state_q <= ST_DROP;
              o_drop  <= 1'b1;
            end
          end
        end

        ST_PREAMBLE: begin
          if (!mac_mii_rxdv) begin
            state_q <= ST_IDLE;
            o_drop  <= 1'b1;
          end else if (mac_mii_rxd == SFD_NIB) begin
            state_q    <= ST_DATA;
            phase_q    <= 1'b0;
            err_q      <= 1'b0;
            crc_q      <= CRC_INIT;
            dl_vld_q   <= '0;
            pend_vld_q <= 1'b0;
          end else if (mac_mii_rxd != PREAMBLE_NIB) begin
            state_q <= ST_DROP;
            o_drop  <= 1'b1;
          end
        end

        ST_DATA: begin
          if (!mac_mii_rxdv) begin
            state_q <= ST_IDLE;
            if (pend_vld_q) begin
              fin_q      <= 1'b1;
              fin_user_q <= err_q | phase_q | (crc_q != CRC_RESIDUE);
            end else begin
              o_drop <= 1'b1;
            end
          end else begin
            if (mac_mii_rxer) err_q <= 1'b1;
            phase_q <= ~phase_q;
            if (phase_q) begin
              crc_q <= crc_d;
              if (STRIP_FCS != 0) dl_vld_q <= {dl_vld_q[2:0], 1'b1};
              if (pend_shift) begin
                pend_vld_q <= 1'b1;
                if (pend_vld_q) begin
                  o_tvalid <= 1'b1;
                  o_tdata  <= pend_q;
                end
              end
            end
          end
        end

        ST_DROP: begin
          if (!mac_mii_rxdv) state_q <= ST_IDLE;
        end

        default: state_q <= ST_DROP;
      endcase
    end
  end

endmodule

// File: doc/mii_rx_deframer.md
MII_RX_DEFRAMER -- requirements
Module: mii_rx_deframer

Interface
REQ-001 SHALL have parameter STRIP_FCS, default 1, meaning 1 = remove the 4 FCS bytes from the output and 0 = pass them through.
REQ-002 SHALL have port mac_mii_rxc  input  1  MII receive clock; the only clock.
REQ-003 SHALL have port mac_mii_rxrst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port mac_mii_rxdv  input  1  MII receive data valid.
REQ-005 SHALL have port mac_mii_rxer  input  1  MII receive error.
REQ-006 SHALL have port mac_mii_rxd  input  4  MII receive nibble, low nibble of each byte first.
REQ-007 SHALL have port o_tvalid  output  1  output byte valid; there is no ready signal and the block never stalls.
REQ-008 SHALL have port o_tdata  output  8  output byte.
REQ-009 SHALL have port o_tlast  output  1  last byte of the frame, qualified by o_tvalid.
REQ-010 SHALL have port o_tuser  output  1  bad frame, qualified by o_tvalid and o_tlast.
REQ-011 SHALL have port o_drop  output  1  one-cycle pulse when a frame is discarded without emitting any byte.

Function
REQ-012 SHALL sample all inputs on the rising edge of mac_mii_rxc and register all outputs.
REQ-013 SHALL implement states IDLE, PREAMBLE, DATA and DROP.
REQ-014 IDLE SHALL move to PREAMBLE on rxdv=1 with rxd=0x5, move to DROP with an o_drop pulse on rxdv=1 with any other rxd, and ignore rxer while rxdv=0.
REQ-015 PREAMBLE SHALL stay on rxd=0x5, move to DATA on rxd=0xD (SFD), move to DROP with an o_drop pulse on any other nibble, and return to IDLE with an o_drop pulse on rxdv=0.
REQ-016 DATA SHALL assemble bytes as {second nibble, first nibble}, toggling a nibble phase bit that is cleared on SFD.
REQ-017 DATA SHALL hold the newest completed byte in a pending register and emit it with o_tlast=0 one cycle after the next byte completes.
REQ-018 When STRIP_FCS=1, a 4-byte delay line SHALL sit ahead of the pending register, so a byte enters pending only once 4 newer bytes exist.
REQ-019 On the first rxdv=0 sample in DATA, the block SHALL emit the pending byte with o_tlast=1 in the following cycle and go to IDLE.
REQ-020 If no pending byte exists at frame end (fewer than 5 bytes with STRIP_FCS=1, or 0 bytes with STRIP_FCS=0), the block SHALL pulse o_drop and emit nothing.
REQ-021 o_tuser at o_tlast SHALL be 1 if any of these hold: rxer was seen in DATA; phase was odd at frame end; CRC check failed.
REQ-022 The CRC SHALL be CRC-32, reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, no final XOR.
REQ-023 The CRC SHALL run over every assembled byte including the FCS, and the check passes iff the residue equals 0xDEBB20E3.
REQ-024 The CRC check SHALL apply regardless of STRIP_FCS.
REQ-025 DROP SHALL emit nothing and return to IDLE on the first rxdv=0 sample.
REQ-026 o_tvalid SHALL assert at most once per 2 cycles.
REQ-027 o_tvalid, o_tlast, o_tuser and o_drop SHALL each be high for exactly 1 cycle per event.
REQ-028 The block SHALL perform no length (runt or oversize) check.

Reset
REQ-029 On mac_mii_rxrst all outputs SHALL be 0 and the state SHALL be DROP.
REQ-030 On reset, the CRC register SHALL be 0xFFFFFFFF and the phase, pending and delay-line valid flags SHALL be cleared.
REQ-031 Reset mid-frame SHALL emit no o_tlast and no o_drop, and SHALL discard the remainder of the frame until rxdv=0.
REQ-032 The DROP state entered by reset SHALL never generate o_drop.

Structure
REQ-033 Package mii_pkg SHALL hold the state enum, the preamble nibble 0x5, the SFD nibble 0xD, the CRC polynomial, the initial value and the residue constant.
REQ-034 A single sub-module eth_crc32_d8 (combinational: 32-bit CRC in plus 8-bit byte in -> 32-bit CRC out) SHALL be instantiated once.

Verification
REQ-035 With STRIP_FCS=1, the bench SHALL send 15 nibbles of 0x5, then 0xD, payload bytes 0x00..0x3B and a correct FCS, and SHALL see 60 bytes 0x00..0x3B with o_tlast on 0x3B, o_tuser=0 and o_drop never.
REQ-036 The bench SHALL send the REQ-035 frame with FCS bit 0 flipped, and SHALL see the same 60 bytes with o_tuser=1 at o_tlast.
REQ-037 The bench SHALL send the REQ-035 frame with rxer=1 for one nibble of byte 10, and SHALL see 60 bytes with o_tuser=1; a separate run with one extra trailing nibble 0x0 SHALL also give o_tuser=1.
REQ-038 The bench SHALL send rxd 0x5,0x5,0x3 with rxdv=1, and SHALL see o_drop high for exactly 1 cycle and no o_tvalid until the next frame, which SHALL be received correctly.
REQ-039 The bench SHALL assert reset for 2 cycles after 20 payload bytes and keep rxdv high for the rest of the frame, and SHALL see no output or o_drop for that frame, then a following good frame received correctly.
REQ-040 With STRIP_FCS=0, the bench SHALL send the REQ-035 frame and see 64 bytes ending in the 4 FCS bytes with o_tuser=0; a frame of 3 bytes with STRIP_FCS=1 SHALL give one o_drop pulse.
